// File: rtl/rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_unit
// Brief    : RV32I fetch stage - fetch PC, single-outstanding imem handshake,
//            instruction register with one-word stall buffer and redirect flush.
// Revision : 1.0
// ============================================================================
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic        funct7_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_BUFFERED = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    localparam logic [31:0] c_pc_step    = 32'd4;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_valid;

    logic        w_consume;
    logic [31:0] w_target;

    assign w_consume = r_valid && !stall;
    assign w_target  = redirect_pc & c_align_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_ir       <= NOP_INSTR;
            r_pc       <= RESET_PC;
            r_buf      <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (redirect_valid && (r_state != S_IDLE)) begin
            // Redirect beats stall; an outstanding request is drained in FLUSH
            r_fetch_pc <= w_target;
            r_ir       <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_buf      <= NOP_INSTR;
            if ((r_state == S_FETCH) && !imem_rvalid)
                r_state <= S_FLUSH;
            else
                r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_rvalid) begin
                        r_fetch_pc <= r_fetch_pc + c_pc_step;
                        if (!r_valid || w_consume) begin
                            r_ir    <= imem_rdata;
                            r_pc    <= r_fetch_pc;
                            r_valid <= 1'b1;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_BUFFERED;
                        end
                    end else if (w_consume) begin
                        r_ir    <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                S_BUFFERED: begin
                    if (!stall) begin
                        r_ir    <= r_buf;
                        r_pc    <= r_fetch_pc - c_pc_step;
                        r_valid <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (imem_rvalid)
                        r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_fetch_pc;
    assign instr_valid  = r_valid;
    assign instr_out    = r_ir;
    assign pc_out       = r_pc;
    assign pc_plus4_out = r_pc + c_pc_step;

    // Decode slices stay unqualified; the NOP in an empty IR keeps them harmless
    assign opcode_out   = r_ir[6:0];
    assign funct3_out   = r_ir[14:12];
    assign funct7_out   = r_ir[30];
    assign rd_out       = r_ir[11:7];
    assign rs1_out      = r_ir[19:15];
    assign rs2_out      = r_ir[24:20];

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_fetch_unit
// Brief    : Scoreboarded bench for rv32i_fetch_unit with a latency-programmable
//            instruction memory model.
// Revision : 1.0
// ============================================================================
module tb_rv32i_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic        funct7_out;
    logic [4:0]  rd_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;

    rv32i_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out),
        .opcode_out     (opcode_out),
        .funct3_out     (funct3_out),
        .funct7_out     (funct7_out),
        .rd_out         (rd_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    logic [31:0] ovr_addr = 32'hFFFF_FFFF;
    logic [31:0] ovr_data = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory image: addi x1,x0,imm with imm from the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ovr_addr) return ovr_data;
        return {a[13:2], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic nxt;
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"},  32'(instr_valid),  32'h0);
        check_eq({tag, "_instr"},  instr_out,         32'h0000_0013);
        check_eq({tag, "_pc"},     pc_out,            32'h0);
        check_eq({tag, "_pc4"},    pc_plus4_out,      32'h4);
        check_eq({tag, "_req"},    32'(imem_req),     32'h0);
        check_eq({tag, "_addr"},   imem_addr,         32'h0);
        check_eq({tag, "_opcode"}, 32'(opcode_out),   32'h13);
        check_eq({tag, "_f3"},     32'(funct3_out),   32'h0);
        check_eq({tag, "_f7"},     32'(funct7_out),   32'h0);
    endtask

    task automatic do_reset;
        nxt;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();
        #1;
        check_reset_vals("rst");
        nxt;
        nxt;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) nxt;
        check_eq({tag, "_drain"}, exp_q.size(), 32'h0);
    endtask

    // Instruction memory: one outstanding request, completes even if req drops
    initial begin : g_mem
        logic        busy;
        logic [31:0] paddr;
        int          cnt;
        busy        = 1'b0;
        paddr       = 32'h0;
        cnt         = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy        = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                if (!busy && imem_req) begin
                    busy  = 1'b1;
                    paddr = imem_addr;
                    cnt   = 0;
                end
                if (busy && cnt >= lat - 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                end else begin
                    imem_rvalid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (reset || imem_rvalid) begin
                busy        = 1'b0;
                imem_rvalid = 1'b0;
            end else if (busy) begin
                cnt++;
            end
        end
    end

    // Scoreboard: every consumed instruction must match the queue head
    initial begin : g_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && instr_valid && !stall && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sb_pc",     pc_out,             e.pc);
                check_eq("sb_instr",  instr_out,          e.instr);
                check_eq("sb_pc4",    pc_plus4_out,       e.pc + 32'd4);
                check_eq("sb_opcode", 32'(opcode_out),    32'(e.instr[6:0]));
                check_eq("sb_funct3", 32'(funct3_out),    32'(e.instr[14:12]));
                check_eq("sb_funct7", 32'(funct7_out),    32'(e.instr[30]));
                check_eq("sb_rd",     32'(rd_out),        32'(e.instr[11:7]));
                check_eq("sb_rs1",    32'(rs1_out),       32'(e.instr[19:15]));
                check_eq("sb_rs2",    32'(rs2_out),       32'(e.instr[24:20]));
            end
        end
    end

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Zero-wait streaming, first valid two edges after release
        lat = 1;
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        nxt;
        check_eq("t1_e1_valid", 32'(instr_valid), 32'h0);
        check_eq("t1_e1_req",   32'(imem_req),    32'h1);
        check_eq("t1_e1_addr",  imem_addr,        32'h0);
        for (int k = 0; k < 3; k++) begin
            nxt;
            check_eq("t1_valid", 32'(instr_valid), 32'h1);
            check_eq("t1_pc",    pc_out,           32'(4 * k));
        end
        wait_drain("t1");

        // Three-cycle memory latency
        lat = 3;
        do_reset();
        push_exp(32'h0); push_exp(32'h4);
        for (int k = 1; k <= 9; k++) begin
            nxt;
            check_eq("t2_req",   32'(imem_req),    32'h1);
            check_eq("t2_addr",  imem_addr,        32'(4 * ((k - 1) / 3)));
            check_eq("t2_valid", 32'(instr_valid), (k == 4 || k == 7) ? 32'h1 : 32'h0);
            if (k == 4 || k == 7)
                check_eq("t2_pc", pc_out, 32'(4 * ((k - 4) / 3)));
        end
        wait_drain("t2");

        // Stall with a word returned while the IR is held
        lat      = 1;
        ovr_addr = 32'h0000_000C;
        ovr_data = 32'h00C0_0003;
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        push_exp(32'hC); push_exp(32'h10); push_exp(32'h14);
        repeat (4) nxt;
        check_eq("t3_pre_pc", pc_out, 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt;
            check_eq("t3_req",   32'(imem_req),    32'h0);
            check_eq("t3_valid", 32'(instr_valid), 32'h1);
            check_eq("t3_pc",    pc_out,           32'h8);
            check_eq("t3_instr", instr_out,        mem_word(32'h8));
        end
        stall = 1'b0;
        nxt;
        check_eq("t3_buf_instr", instr_out, 32'h00C0_0003);
        check_eq("t3_buf_pc",    pc_out,    32'hC);
        wait_drain("t3");
        ovr_addr = 32'hFFFF_FFFF;

        // Redirect while a slow fetch is in flight
        lat = 3;
        do_reset();
        push_exp(32'h0);
        repeat (5) nxt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        push_exp(32'h100); push_exp(32'h104);
        nxt;
        redirect_valid = 1'b0;
        check_eq("t4_flush_addr",  imem_addr,        32'h100);
        check_eq("t4_flush_req",   32'(imem_req),    32'h0);
        check_eq("t4_flush_valid", 32'(instr_valid), 32'h0);
        check_eq("t4_flush_instr", instr_out,        32'h0000_0013);
        nxt;
        check_eq("t4_req",   32'(imem_req),    32'h1);
        check_eq("t4_addr",  imem_addr,        32'h100);
        check_eq("t4_valid", 32'(instr_valid), 32'h0);
        nxt;
        nxt;
        check_eq("t4_wait_valid", 32'(instr_valid), 32'h0);
        nxt;
        check_eq("t4_new_valid", 32'(instr_valid), 32'h1);
        check_eq("t4_new_pc",    pc_out,           32'h100);
        wait_drain("t4");

        // Redirect coincident with rvalid and stall
        lat = 1;
        do_reset();
        push_exp(32'h0);
        repeat (3) nxt;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        push_exp(32'h200); push_exp(32'h204);
        nxt;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        check_eq("t5_instr", instr_out,        32'h0000_0013);
        check_eq("t5_valid", 32'(instr_valid), 32'h0);
        check_eq("t5_addr",  imem_addr,        32'h200);
        check_eq("t5_req",   32'(imem_req),    32'h1);
        wait_drain("t5");

        // PC wrap at the top of the address space
        do_reset();
        push_exp(32'h0);
        repeat (2) nxt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
        nxt;
        redirect_valid = 1'b0;
        check_eq("t6_addr", imem_addr, 32'hFFFF_FFFC);
        wait_drain("t6");

        // Asynchronous reset in the middle of an active request
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        repeat (4) nxt;
        @(posedge clk);
        #3;
        check_eq("t7_pre_req", 32'(imem_req), 32'h1);
        reset = 1'b1;
        #1;
        check_reset_vals("t7_async");
        exp_q.delete();
        nxt;
        nxt;
        reset = 1'b0;
        push_exp(32'h0); push_exp(32'h4);
        nxt;
        check_eq("t7_restart_req",  32'(imem_req), 32'h1);
        check_eq("t7_restart_addr", imem_addr,     32'h0);
        wait_drain("t7");

        repeat (2) nxt;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_fetch_unit.md
# rv32i_fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of the control unit. It holds the fetch PC, runs a single-outstanding request/response handshake to instruction memory, and keeps the instruction register (IR). The IR feeds `opcode_out`, `funct3_out` and `funct7_out` straight into the control unit. It honours the control unit's `stall`, buffers one word returned during a stall, and flushes on jump/branch redirects.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: IR contents when no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  from the control unit; while high, the IR must not advance.
- `redirect_valid`  in  1  taken branch/jump (JAL, JALR) this cycle.
- `redirect_pc`  in  32  target address; bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1  fetch request; held high until `imem_rvalid`.
- `imem_addr`  out  32  fetch address, always equal to `fetch_pc`.
- `imem_rvalid`  in  1  read data valid; only meaningful while `imem_req` is high.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  IR holds a valid instruction.
- `instr_out`  out  32  IR contents.
- `pc_out`  out  32  PC of the instruction in the IR.
- `pc_plus4_out`  out  32  `pc_out + 4`, used for JAL/JALR writeback.
- `opcode_out`  out  7  IR[6:0].
- `funct3_out`  out  3  IR[14:12].
- `funct7_out`  out  1  IR[30].
- `rd_out`, `rs1_out`, `rs2_out`  out  5 each  IR[11:7], IR[19:15], IR[24:20].

## Operation
- "Consume" occurs in any cycle with `instr_valid && !stall`.
- States: IDLE, FETCH, BUFFERED, FLUSH.
- **IDLE**
  - Entered on reset; `imem_req=0`.
  - Moves to FETCH unconditionally on the next clock edge.
- **FETCH**
  - `imem_req=1`, `imem_addr=fetch_pc`.
  - On `imem_rvalid`, if the IR is empty or is consumed this cycle: IR←rdata, `pc_out`←`fetch_pc`, `fetch_pc`←`fetch_pc+4`, `instr_valid`←1. Stay in FETCH.
  - On `imem_rvalid` while the IR is valid and stalled: buffer←rdata, `fetch_pc`←`fetch_pc+4`, go to BUFFERED.
  - No `imem_rvalid` and the IR is consumed: `instr_valid`←0 and IR←`NOP_INSTR`.
- **BUFFERED**
  - `imem_req=0`.
  - When `!stall`: IR←buffer, `pc_out`←`fetch_pc-4`, `instr_valid`←1, go to FETCH.
- **FLUSH**
  - `imem_req=0`, so no new request is issued. The stale response is awaited and discarded.
  - On `imem_rvalid`, go to FETCH.
- **Redirect** (highest priority, any state except IDLE):
  - `fetch_pc`←{`redirect_pc`[31:2],2'b00}.
  - `instr_valid`←0, IR←`NOP_INSTR`, buffer discarded.
  - Next state is FLUSH if in FETCH with `imem_req` high and no `imem_rvalid` this cycle. Otherwise it is FETCH, and any `imem_rvalid` data arriving in the same cycle is dropped.
- Redirect while `stall` is high: the redirect still wins, and the stalled instruction is discarded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Decode field outputs are combinational slices of the IR; they are never qualified by `instr_valid`. The NOP value makes them benign when the IR is empty.

## Timing
- Reset values:
  - state=IDLE, `fetch_pc`=`imem_addr`=`RESET_PC`, `imem_req`=0.
  - `instr_valid`=0, `instr_out`=`NOP_INSTR`.
  - `pc_out`=`RESET_PC`, `pc_plus4_out`=`RESET_PC+4`.
  - `opcode_out`=7'b0010011, `funct3_out`=0, `funct7_out`=0.
- Reset asserted mid-request returns to IDLE immediately; any later `imem_rvalid` is ignored because `imem_req` is 0.
- `imem_rvalid` may arrive in the same cycle `imem_req` rises (zero wait). With a zero-wait memory and no stalls, throughput is 1 instruction/cycle.
- First `instr_valid` occurs 2 cycles after reset release with zero-wait memory: edge 1 IDLE→FETCH, edge 2 IR loaded.
- Fetch-to-IR latency: IR updates on the edge where `imem_rvalid` is sampled.
- Load-use stall: at most one word is buffered. No request is issued while the buffer is full.
- Redirect penalty: 1 cycle with zero-wait memory, plus the remaining latency of an in-flight fetch.

## Test plan
- Reset, zero-wait memory returning `addi` words at 0x0, 0x4, 0x8 → `instr_valid` rises at cycle 2; `pc_out` steps 0x0, 0x4, 0x8 on consecutive cycles; `opcode_out`=0010011.
- 3-cycle memory latency → `imem_req` held high with `imem_addr` stable 3 cycles per word; `instr_valid` low between words.
- `stall` high for 4 cycles with word 0x00C0_0003 returned mid-stall → BUFFERED entered, `imem_req`=0, IR unchanged. On `stall` low, IR=0x00C0_0003 and `pc_out`=previous+4.
- Redirect to 0x0000_0102 while a fetch is in flight → `fetch_pc`=0x100, FLUSH drops the stale word, next request addr=0x100, `instr_valid`=0 until the new word arrives.
- Redirect coincident with `imem_rvalid` and with `stall` high → data dropped, `instr_out`=0x0000_0013, next `imem_addr`=target.
- `reset` pulsed while `imem_req`=1 → all outputs at reset values asynchronously; fetch restarts at `RESET_PC`.
